// File: rtl/alu_rs_pkg.sv
// Shared backend definitions: ALU/branch opcode encoding and default tag width.
package alu_rs_pkg;

  localparam int TAG_W_DEF = 6;
  localparam int XLEN      = 32;

  typedef enum logic [3:0] {
    ADD_I  = 4'd0,
    SUB_I  = 4'd1,
    AND_I  = 4'd2,
    OR_I   = 4'd3,
    XOR_I  = 4'd4,
    SLL_I  = 4'd5,
    SRL_I  = 4'd6,
    SRA_I  = 4'd7,
    SLT_I  = 4'd8,
    SLTU_I = 4'd9,
    BEQ_I  = 4'd10,
    BNE_I  = 4'd11,
    BLT_I  = 4'd12,
    BGE_I  = 4'd13,
    JAL_I  = 4'd14,
    JALR_I = 4'd15
  } instr_opcode;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-eligible picker: grants the eligible entry that no other eligible entry is older than.
module rs_age_select #(
  parameter int N = 4
) (
  input  logic [N-1:0][N-1:0] age,
  input  logic [N-1:0]        elig,
  output logic [N-1:0]        gnt
);

  // age[j][i] set means entry j was dispatched before entry i
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N-1:0] older;
    for (genvar j = 0; j < N; j++) begin : g_col
      assign older[j] = elig[j] & age[j][i];
    end
    assign gnt[i] = elig[i] & ~|older;
  end

endmodule

// File: rtl/alu_rs.sv
// ALU/branch reservation station: CDB wakeup, age-ordered single issue, registered issue payload.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  instr_opcode      disp_opcode,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic [31:0]      disp_src1_val,
  input  logic [31:0]      disp_src2_val,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             flush,
  output logic             alu_en,
  output instr_opcode      opcode,
  output logic [31:0]      val1,
  output logic [31:0]      val2,
  output logic [31:0]      imm_agex,
  output logic [31:0]      pc_agex,
  output logic [TAG_W-1:0] dst_tag_agex
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } src_t;

  typedef struct packed {
    logic             valid;
    instr_opcode      opcode;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dst;
    src_t             s1;
    src_t             s2;
  } ent_t;

  function automatic src_t wake(input src_t s, input logic cv,
                                input logic [TAG_W-1:0] ct, input logic [31:0] cval);
    src_t r;
    r = s;
    if (cv && !s.rdy && s.tag == ct) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction

  ent_t [DEPTH-1:0]            ent_q, ent_d;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic                        alu_en_q, alu_en_d;
  instr_opcode                 opcode_q, opcode_d;
  logic [31:0]                 val1_q, val1_d, val2_q, val2_d;
  logic [31:0]                 imm_q, imm_d, pc_q, pc_d;
  logic [TAG_W-1:0]            dst_q, dst_d;

  logic [DEPTH-1:0] valid_vec, elig, gnt;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire;
  ent_t             new_ent;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign valid_vec[i] = ent_q[i].valid;
    assign elig[i]      = ent_q[i].valid & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
  end

  // Ready depends on registered occupancy only, so an issuing slot frees next cycle.
  assign disp_ready = ~&valid_vec;
  assign disp_fire  = disp_valid & disp_ready & ~flush;

  rs_age_select #(.N(DEPTH)) u_sel (
    .age  (age_q),
    .elig (elig),
    .gnt  (gnt)
  );

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !found) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Same-cycle CDB match is folded into the new entry so the wakeup is not lost.
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.opcode = disp_opcode;
    new_ent.imm    = disp_imm;
    new_ent.pc     = disp_pc;
    new_ent.dst    = disp_dst_tag;
    new_ent.s1     = wake('{rdy: disp_src1_rdy, tag: disp_src1_tag, val: disp_src1_val},
                          cdb_valid, cdb_tag, cdb_val);
    new_ent.s2     = wake('{rdy: disp_src2_rdy, tag: disp_src2_tag, val: disp_src2_val},
                          cdb_valid, cdb_tag, cdb_val);
  end

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        ent_d[i].s1 = wake(ent_q[i].s1, cdb_valid, cdb_tag, cdb_val);
        ent_d[i].s2 = wake(ent_q[i].s2, cdb_valid, cdb_tag, cdb_val);
      end
      if (gnt[i]) ent_d[i].valid = 1'b0;
    end
    if (disp_fire) begin
      ent_d[free_idx] = new_ent;
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = ent_q[j].valid;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    alu_en_d = |gnt & ~flush;
    opcode_d = opcode_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    dst_d    = dst_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i] && !flush) begin
        opcode_d = ent_q[i].opcode;
        val1_d   = ent_q[i].s1.val;
        val2_d   = ent_q[i].s2.val;
        imm_d    = ent_q[i].imm;
        pc_d     = ent_q[i].pc;
        dst_d    = ent_q[i].dst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q    <= '0;
      age_q    <= '0;
      alu_en_q <= 1'b0;
      opcode_q <= ADD_I;
      val1_q   <= '0;
      val2_q   <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      dst_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      age_q    <= age_d;
      alu_en_q <= alu_en_d;
      opcode_q <= opcode_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      dst_q    <= dst_d;
    end
  end

  assign alu_en       = alu_en_q;
  assign opcode       = opcode_q;
  assign val1         = val1_q;
  assign val2         = val2_q;
  assign imm_agex     = imm_q;
  assign pc_agex      = pc_q;
  assign dst_tag_agex = dst_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_valid, disp_ready;
  instr_opcode   disp_opcode;
  logic [31:0]   disp_imm, disp_pc;
  logic          disp_src1_rdy, disp_src2_rdy;
  logic [TW-1:0] disp_src1_tag, disp_src2_tag;
  logic [31:0]   disp_src1_val, disp_src2_val;
  logic [TW-1:0] disp_dst_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_val;
  logic          flush;
  logic          alu_en;
  instr_opcode   opcode;
  logic [31:0]   val1, val2, imm_agex, pc_agex;
  logic [TW-1:0] dst_tag_agex;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .flush(flush), .alu_en(alu_en), .opcode(opcode),
    .val1(val1), .val2(val2), .imm_agex(imm_agex), .pc_agex(pc_agex),
    .dst_tag_agex(dst_tag_agex)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input instr_opcode op, input logic r1, input logic [TW-1:0] t1,
                      input logic [31:0] v1, input logic r2, input logic [TW-1:0] t2,
                      input logic [31:0] v2, input logic [TW-1:0] dst);
    disp_valid    = 1'b1;
    disp_opcode   = op;
    disp_src1_rdy = r1;
    disp_src1_tag = t1;
    disp_src1_val = v1;
    disp_src2_rdy = r2;
    disp_src2_tag = t2;
    disp_src2_val = v2;
    disp_dst_tag  = dst;
    disp_imm      = 32'h100 + 32'(dst);
    disp_pc       = 32'h1000 + 32'(dst);
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [31:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_val   = v;
  endtask

  task automatic clear_rs();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  typedef struct {
    instr_opcode   op;
    logic          r1;
    logic [TW-1:0] t1;
    logic [31:0]   v1;
    logic          r2;
    logic [TW-1:0] t2;
    logic [31:0]   v2;
    logic [TW-1:0] dst;
    logic          cv;
    logic [TW-1:0] ct;
    logic [31:0]   cval;
    logic          ex_en;
    logic [31:0]   ex_v1;
    logic [31:0]   ex_v2;
  } vec_t;

  typedef struct {
    instr_opcode   op;
    logic          r1;
    logic [TW-1:0] t1;
    logic [31:0]   v1;
    logic          r2;
    logic [TW-1:0] t2;
    logic [31:0]   v2;
    logic [31:0]   imm;
    logic [31:0]   pc;
    logic [TW-1:0] dst;
  } mop_t;

  function automatic mop_t mwake(input mop_t m, input logic cv, input logic [TW-1:0] ct,
                                 input logic [31:0] cval);
    mop_t r;
    r = m;
    if (cv && !r.r1 && r.t1 == ct) begin r.r1 = 1'b1; r.v1 = cval; end
    if (cv && !r.r2 && r.t2 == ct) begin r.r2 = 1'b1; r.v2 = cval; end
    return r;
  endfunction

  vec_t vt[6];
  mop_t mq[$];

  initial begin
    vt[0] = '{ADD_I, 1'b1, 6'd0,  32'd5,        1'b1, 6'd0,  32'd7, 6'd1,
              1'b0, 6'd0,  32'd0,      1'b1, 32'd5,        32'd7};
    vt[1] = '{XOR_I, 1'b1, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd0,  32'd0, 6'd2,
              1'b1, 6'd5,  32'h1,      1'b1, 32'hFFFFFFFF, 32'd0};
    vt[2] = '{ADD_I, 1'b0, 6'd9,  32'd0,        1'b1, 6'd0,  32'd3, 6'd3,
              1'b1, 6'd9,  32'hAA,     1'b1, 32'hAA,       32'd3};
    vt[3] = '{BEQ_I, 1'b0, 6'd9,  32'd0,        1'b0, 6'd9,  32'd0, 6'd4,
              1'b1, 6'd9,  32'h55,     1'b1, 32'h55,       32'h55};
    vt[4] = '{SUB_I, 1'b0, 6'd4,  32'd0,        1'b1, 6'd0,  32'd1, 6'd5,
              1'b1, 6'd5,  32'h1,      1'b0, 32'd0,        32'd0};
    vt[5] = '{OR_I,  1'b1, 6'd0,  32'h77,       1'b0, 6'd63, 32'd0, 6'd63,
              1'b1, 6'd63, 32'h1234,   1'b1, 32'h77,       32'h1234};

    rst = 1'b1;
    idle();
    disp_opcode = ADD_I;
    {disp_src1_rdy, disp_src2_rdy} = 2'b00;
    {disp_src1_tag, disp_src2_tag, disp_dst_tag, cdb_tag} = '0;
    {disp_src1_val, disp_src2_val, disp_imm, disp_pc, cdb_val} = '0;
    #12;
    chk1("rst_alu_en", alu_en, 1'b0);
    chk1("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_val1", val1, 32'd0);
    chk("rst_dst", 32'(dst_tag_agex), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // single-op vectors, each into an emptied station
    for (int r = 0; r < 6; r++) begin
      clear_rs();
      disp(vt[r].op, vt[r].r1, vt[r].t1, vt[r].v1, vt[r].r2, vt[r].t2, vt[r].v2, vt[r].dst);
      if (vt[r].cv) cdb(vt[r].ct, vt[r].cval);
      step();
      idle();
      chk1($sformatf("tbl%0d_en_early", r), alu_en, 1'b0);
      step();
      chk1($sformatf("tbl%0d_en", r), alu_en, vt[r].ex_en);
      if (vt[r].ex_en) begin
        chk($sformatf("tbl%0d_val1", r), val1, vt[r].ex_v1);
        chk($sformatf("tbl%0d_val2", r), val2, vt[r].ex_v2);
        chk($sformatf("tbl%0d_dst", r), 32'(dst_tag_agex), 32'(vt[r].dst));
        chk($sformatf("tbl%0d_op", r), 32'(opcode), 32'(vt[r].op));
        chk($sformatf("tbl%0d_imm", r), imm_agex, 32'h100 + 32'(vt[r].dst));
        chk($sformatf("tbl%0d_pc", r), pc_agex, 32'h1000 + 32'(vt[r].dst));
      end
      step();
      chk1($sformatf("tbl%0d_en_after", r), alu_en, 1'b0);
    end

    // wakeup two cycles after dispatch
    clear_rs();
    disp(SUB_I, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd2, 6'd7);
    step(); idle();
    step(); chk1("wk_en_wait", alu_en, 1'b0);
    cdb(6'd3, 32'h10);
    step(); idle(); chk1("wk_en_edge", alu_en, 1'b0);
    step();
    chk1("wk_en", alu_en, 1'b1);
    chk("wk_val1", val1, 32'h10);
    chk("wk_val2", val2, 32'd2);

    // full station, wake one, then flush with an eligible op pending
    clear_rs();
    for (int k = 0; k < 4; k++) begin
      disp(ADD_I, 1'b0, 6'(10 + k), 32'd0, 1'b1, 6'd0, 32'(k), 6'(20 + k));
      step();
    end
    idle();
    chk1("full_ready", disp_ready, 1'b0);
    cdb(6'd12, 32'h99);
    step(); idle();
    chk1("full_en_wait", alu_en, 1'b0);
    chk1("full_ready_hold", disp_ready, 1'b0);
    step();
    chk1("full_en", alu_en, 1'b1);
    chk("full_dst", 32'(dst_tag_agex), 32'd22);
    chk("full_val1", val1, 32'h99);
    chk1("full_ready_freed", disp_ready, 1'b1);
    disp(OR_I, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd30);
    step(); idle();
    flush = 1'b1;
    step(); flush = 1'b0;
    chk1("fl_en", alu_en, 1'b0);
    chk1("fl_ready", disp_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cdb(k == 2 ? 6'd13 : 6'(10 + k), 32'h5);
      step(); idle();
      chk1($sformatf("fl_no_issue%0d", k), alu_en, 1'b0);
    end

    // two eligible on one edge: dispatch order wins
    clear_rs();
    disp(ADD_I, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0, 6'd1);
    step();
    disp(SUB_I, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0, 6'd2);
    step(); idle();
    cdb(6'd20, 32'd5);
    step(); idle();
    step(); chk1("age_en_a", alu_en, 1'b1); chk("age_dst_a", 32'(dst_tag_agex), 32'd1);
    step(); chk1("age_en_b", alu_en, 1'b1); chk("age_dst_b", 32'(dst_tag_agex), 32'd2);
    step(); chk1("age_en_none", alu_en, 1'b0);

    // older op sits at a higher index than a younger one
    clear_rs();
    disp(ADD_I, 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd0, 6'd3);
    step();
    disp(ADD_I, 1'b0, 6'd22, 32'd0, 1'b1, 6'd0, 32'd0, 6'd4);
    step(); idle();
    cdb(6'd21, 32'd1);
    step(); idle();
    step(); chk("ix_dst_x", 32'(dst_tag_agex), 32'd3);
    disp(ADD_I, 1'b0, 6'd22, 32'd0, 1'b1, 6'd0, 32'd0, 6'd5);
    step(); idle();
    cdb(6'd22, 32'd2);
    step(); idle();
    step(); chk("ix_dst_y", 32'(dst_tag_agex), 32'd4);
    step(); chk("ix_dst_z", 32'(dst_tag_agex), 32'd5);

    // random traffic against the in-order queue model
    clear_rs();
    mq.delete();
    for (int c = 0; c < 1500; c++) begin
      mop_t n, e;
      int   sel;
      logic exp_en, exp_rdy;
      disp_valid    = 1'($urandom_range(0, 1));
      disp_opcode   = instr_opcode'($urandom_range(0, 15));
      disp_src1_rdy = 1'($urandom_range(0, 1));
      disp_src2_rdy = 1'($urandom_range(0, 1));
      disp_src1_tag = 6'($urandom_range(0, 7));
      disp_src2_tag = 6'($urandom_range(0, 7));
      disp_src1_val = $urandom;
      disp_src2_val = $urandom;
      disp_imm      = $urandom;
      disp_pc       = $urandom;
      disp_dst_tag  = 6'($urandom_range(0, 63));
      cdb_valid     = ($urandom_range(0, 2) != 0);
      cdb_tag       = 6'($urandom_range(0, 7));
      cdb_val       = $urandom;
      flush         = ($urandom_range(0, 39) == 0);

      exp_rdy = (mq.size() < DEPTH);
      chk1("rnd_ready", disp_ready, exp_rdy);
      sel = -1;
      foreach (mq[k]) if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
      exp_en = 1'b0;
      e = '{ADD_I, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0};
      if (!flush && sel >= 0) begin
        exp_en = 1'b1;
        e = mq[sel];
        mq.delete(sel);
      end
      foreach (mq[k]) mq[k] = mwake(mq[k], cdb_valid, cdb_tag, cdb_val);
      if (disp_valid && exp_rdy && !flush) begin
        n = '{disp_opcode, disp_src1_rdy, disp_src1_tag, disp_src1_val,
              disp_src2_rdy, disp_src2_tag, disp_src2_val, disp_imm, disp_pc, disp_dst_tag};
        mq.push_back(mwake(n, cdb_valid, cdb_tag, cdb_val));
      end
      if (flush) mq.delete();
      step();
      chk1("rnd_en", alu_en, exp_en);
      if (exp_en) begin
        chk("rnd_op", 32'(opcode), 32'(e.op));
        chk("rnd_val1", val1, e.v1);
        chk("rnd_val2", val2, e.v2);
        chk("rnd_imm", imm_agex, e.imm);
        chk("rnd_pc", pc_agex, e.pc);
        chk("rnd_dst", 32'(dst_tag_agex), 32'(e.dst));
      end
    end

    // asynchronous reset while an op is issuing and another is held
    clear_rs();
    disp(ADD_I, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22, 6'd8);
    step();
    disp(SUB_I, 1'b1, 6'd0, 32'h33, 1'b1, 6'd0, 32'h44, 6'd9);
    step(); idle();
    chk1("mrst_pre_en", alu_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("mrst_en", alu_en, 1'b0);
    chk("mrst_val1", val1, 32'd0);
    chk1("mrst_ready", disp_ready, 1'b1);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1($sformatf("mrst_no_issue%0d", k), alu_en, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
